// File: rtl/peak_window_timer_if.sv
// Control and status bundle for peak_window_timer: time load, window-table write,
// and the registered time / peak classification outputs.
interface peak_window_timer_if;
    logic       tick;
    logic       load_en;
    logic [7:0] load_hours;
    logic [7:0] load_min;
    logic       load_pm;
    logic       wr_en;
    logic [2:0] wr_idx;
    logic [7:0] wr_start;
    logic [7:0] wr_end;
    logic       wr_ena;
    logic [7:0] hours;
    logic [7:0] minutes;
    logic       pm;
    logic       peak;
    logic       peak_warn;
    logic [2:0] win_id;
    logic       load_err;

    modport master (
        output tick, load_en, load_hours, load_min, load_pm,
               wr_en, wr_idx, wr_start, wr_end, wr_ena,
        input  hours, minutes, pm, peak, peak_warn, win_id, load_err
    );

    modport slave (
        input  tick, load_en, load_hours, load_min, load_pm,
               wr_en, wr_idx, wr_start, wr_end, wr_ena,
        output hours, minutes, pm, peak, peak_warn, win_id, load_err
    );
endinterface

// File: rtl/peak_window_timer.sv
// 12-hour BCD time-of-day keeper with a programmable table of peak windows,
// producing registered peak / advance-warning / window-index outputs.
module peak_window_timer #(
    parameter int NUM_WIN       = 3,
    parameter int TICKS_PER_MIN = 60,
    parameter int WARN_MIN      = 5
) (
    input  logic               clk,
    input  logic               reset,
    peak_window_timer_if.slave bus
);
    localparam int              PW         = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam logic [PW-1:0]   PRESC_LAST = PW'(TICKS_PER_MIN - 1);
    localparam logic [11:0]     WARN_LIM   = 12'(WARN_MIN);
    localparam logic [11:0]     DAY_MIN    = 12'd1440;
    localparam logic [4:0]      DEF_START [8] = '{5'd7, 5'd12, 5'd17, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    localparam logic [4:0]      DEF_END   [8] = '{5'd9, 5'd14, 5'd19, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0};
    localparam logic [7:0]      DEF_ENA       = 8'b0000_0111;

    function automatic logic bcd_digits_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic hour12_ok(input logic [7:0] v);
        return bcd_digits_ok(v) &&
               (((v[7:4] == 4'd0) && (v[3:0] != 4'd0)) || ((v[7:4] == 4'd1) && (v[3:0] <= 4'd2)));
    endfunction

    function automatic logic minute_ok(input logic [7:0] v);
        return (v[7:4] <= 4'd5) && (v[3:0] <= 4'd9);
    endfunction

    function automatic logic hour24_ok(input logic [7:0] v);
        return bcd_digits_ok(v) && ((v[7:4] < 4'd2) || ((v[7:4] == 4'd2) && (v[3:0] <= 4'd3)));
    endfunction

    function automatic logic [4:0] bcd_to_bin5(input logic [7:0] v);
        return 5'(v[7:4]) * 5'd10 + 5'(v[3:0]);
    endfunction

    function automatic logic [5:0] bcd_to_bin6(input logic [7:0] v);
        return 6'(v[7:4]) * 6'd10 + 6'(v[3:0]);
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            return {v[7:4] + 4'd1, 4'd0};
        end else begin
            return {v[7:4], v[3:0] + 4'd1};
        end
    endfunction

    logic [7:0]    hours_q, hours_d;
    logic [7:0]    min_q, min_d;
    logic          pm_q, pm_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          load_err_q, load_err_d;
    logic          peak_q, peak_d;
    logic          warn_q, warn_d;
    logic [2:0]    win_q, win_d;
    logic [4:0]    wstart_q [NUM_WIN];
    logic [4:0]    wstart_d [NUM_WIN];
    logic [4:0]    wend_q   [NUM_WIN];
    logic [4:0]    wend_d   [NUM_WIN];
    logic          wena_q   [NUM_WIN];
    logic          wena_d   [NUM_WIN];

    logic [4:0]    h12_s;
    logic [4:0]    h24_s;
    logic [10:0]   mod_s;
    logic [11:0]   dist_s;
    logic          match_s;
    logic          hit_s;
    logic          warn_any_s;

    // Time keeping: load has priority and drops a coincident tick.
    always_comb begin
        hours_d    = hours_q;
        min_d      = min_q;
        pm_d       = pm_q;
        presc_d    = presc_q;
        load_err_d = 1'b0;
        if (bus.load_en) begin
            if (hour12_ok(bus.load_hours) && minute_ok(bus.load_min)) begin
                hours_d = bus.load_hours;
                min_d   = bus.load_min;
                pm_d    = bus.load_pm;
                presc_d = PW'(0);
            end else begin
                load_err_d = 1'b1;
            end
        end else if (bus.tick) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = PW'(0);
                if (min_q == 8'h59) begin
                    min_d = 8'h00;
                    if (hours_q == 8'h12) begin
                        hours_d = 8'h01;
                    end else if (hours_q == 8'h11) begin
                        hours_d = 8'h12;
                        pm_d    = ~pm_q;
                    end else begin
                        hours_d = bcd_inc(hours_q);
                    end
                end else begin
                    min_d = bcd_inc(min_q);
                end
            end else begin
                presc_d = presc_q + PW'(1);
            end
        end else begin
            presc_d = presc_q;
        end
    end

    // Window table write; out-of-range index or bad hours leave the table intact.
    always_comb begin
        for (int i = 0; i < NUM_WIN; i++) begin
            wstart_d[i] = wstart_q[i];
            wend_d[i]   = wend_q[i];
            wena_d[i]   = wena_q[i];
            if (bus.wr_en && (bus.wr_idx == 3'(i)) &&
                hour24_ok(bus.wr_start) && hour24_ok(bus.wr_end)) begin
                wstart_d[i] = bcd_to_bin5(bus.wr_start);
                wend_d[i]   = bcd_to_bin5(bus.wr_end);
                wena_d[i]   = bus.wr_ena;
            end else begin
                wena_d[i]   = wena_q[i];
            end
        end
    end

    // Classification of the current time; scanning downward lets the lowest index win.
    always_comb begin
        h12_s = bcd_to_bin5(hours_q);
        if (h12_s == 5'd12) begin
            h24_s = pm_q ? 5'd12 : 5'd0;
        end else begin
            h24_s = pm_q ? (h12_s + 5'd12) : h12_s;
        end
        mod_s      = 11'(h24_s) * 11'd60 + 11'(bcd_to_bin6(min_q));
        hit_s      = 1'b0;
        warn_any_s = 1'b0;
        win_d      = 3'd0;
        match_s    = 1'b0;
        dist_s     = 12'd0;
        for (int i = NUM_WIN - 1; i >= 0; i--) begin
            if (wstart_q[i] <= wend_q[i]) begin
                match_s = (h24_s >= wstart_q[i]) && (h24_s <= wend_q[i]);
            end else begin
                match_s = (h24_s >= wstart_q[i]) || (h24_s <= wend_q[i]);
            end
            if (wena_q[i] && match_s) begin
                hit_s = 1'b1;
                win_d = 3'(i);
            end else begin
                hit_s = hit_s;
            end
            // Minutes until this window opens, modulo one day.
            dist_s = 12'(wstart_q[i]) * 12'd60 + DAY_MIN - 12'(mod_s);
            if (dist_s >= DAY_MIN) begin
                dist_s = dist_s - DAY_MIN;
            end else begin
                dist_s = dist_s;
            end
            if (wena_q[i] && (dist_s >= 12'd1) && (dist_s <= WARN_LIM)) begin
                warn_any_s = 1'b1;
            end else begin
                warn_any_s = warn_any_s;
            end
        end
        peak_d = hit_s;
        warn_d = warn_any_s && !hit_s;
    end

    // State and output registers; reset also restores the default window table.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hours_q    <= 8'h12;
            min_q      <= 8'h00;
            pm_q       <= 1'b0;
            presc_q    <= PW'(0);
            load_err_q <= 1'b0;
            peak_q     <= 1'b0;
            warn_q     <= 1'b0;
            win_q      <= 3'd0;
            for (int i = 0; i < NUM_WIN; i++) begin
                wstart_q[i] <= DEF_START[i];
                wend_q[i]   <= DEF_END[i];
                wena_q[i]   <= DEF_ENA[i];
            end
        end else begin
            hours_q    <= hours_d;
            min_q      <= min_d;
            pm_q       <= pm_d;
            presc_q    <= presc_d;
            load_err_q <= load_err_d;
            peak_q     <= peak_d;
            warn_q     <= warn_d;
            win_q      <= win_d;
            for (int i = 0; i < NUM_WIN; i++) begin
                wstart_q[i] <= wstart_d[i];
                wend_q[i]   <= wend_d[i];
                wena_q[i]   <= wena_d[i];
            end
        end
    end

    assign bus.hours     = hours_q;
    assign bus.minutes   = min_q;
    assign bus.pm        = pm_q;
    assign bus.peak      = peak_q;
    assign bus.peak_warn = warn_q;
    assign bus.win_id    = win_q;
    assign bus.load_err  = load_err_q;
endmodule

// File: tb/tb_peak_window_timer.sv
// Directed bench for peak_window_timer: one instance at one tick per minute with the
// default table, one at three ticks per minute with warnings disabled.
module tb_peak_window_timer;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    peak_window_timer_if bus_a ();
    peak_window_timer_if bus_b ();

    peak_window_timer #(.NUM_WIN(3), .TICKS_PER_MIN(1), .WARN_MIN(5)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a)
    );
    peak_window_timer #(.NUM_WIN(1), .TICKS_PER_MIN(3), .WARN_MIN(0)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load_a(input logic [7:0] h, input logic [7:0] m, input logic p);
        bus_a.load_en    = 1'b1;
        bus_a.load_hours = h;
        bus_a.load_min   = m;
        bus_a.load_pm    = p;
        cyc(1);
        bus_a.load_en    = 1'b0;
    endtask

    task automatic tick_a(input int n);
        bus_a.tick = 1'b1;
        cyc(n);
        bus_a.tick = 1'b0;
    endtask

    task automatic write_a(input logic [2:0] idx, input logic [7:0] s, input logic [7:0] e, input logic en);
        bus_a.wr_en    = 1'b1;
        bus_a.wr_idx   = idx;
        bus_a.wr_start = s;
        bus_a.wr_end   = e;
        bus_a.wr_ena   = en;
        cyc(1);
        bus_a.wr_en    = 1'b0;
    endtask

    task automatic load_b(input logic [7:0] h, input logic [7:0] m, input logic p, input logic with_tick);
        bus_b.load_en    = 1'b1;
        bus_b.load_hours = h;
        bus_b.load_min   = m;
        bus_b.load_pm    = p;
        bus_b.tick       = with_tick;
        cyc(1);
        bus_b.load_en    = 1'b0;
        bus_b.tick       = 1'b0;
    endtask

    task automatic tick_b(input int n);
        bus_b.tick = 1'b1;
        cyc(n);
        bus_b.tick = 1'b0;
    endtask

    task automatic check_time_a(input string tag, input logic [7:0] h, input logic [7:0] m, input logic p);
        check({tag, "_hours"}, 32'(bus_a.hours), 32'(h));
        check({tag, "_min"}, 32'(bus_a.minutes), 32'(m));
        check({tag, "_pm"}, 32'(bus_a.pm), 32'(p));
    endtask

    task automatic check_cls_a(input string tag, input logic pk, input logic wn, input logic [2:0] id);
        check({tag, "_peak"}, 32'(bus_a.peak), 32'(pk));
        check({tag, "_warn"}, 32'(bus_a.peak_warn), 32'(wn));
        check({tag, "_win"}, 32'(bus_a.win_id), 32'(id));
    endtask

    initial begin
        reset = 1'b1;
        {bus_a.tick, bus_a.load_en, bus_a.load_pm, bus_a.wr_en, bus_a.wr_ena} = 5'd0;
        {bus_a.load_hours, bus_a.load_min, bus_a.wr_start, bus_a.wr_end} = 32'd0;
        bus_a.wr_idx = 3'd0;
        {bus_b.tick, bus_b.load_en, bus_b.load_pm, bus_b.wr_en, bus_b.wr_ena} = 5'd0;
        {bus_b.load_hours, bus_b.load_min, bus_b.wr_start, bus_b.wr_end} = 32'd0;
        bus_b.wr_idx = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check_time_a("rst", 8'h12, 8'h00, 1'b0);
        check_cls_a("rst", 1'b0, 1'b0, 3'd0);
        check("rst_load_err", 32'(bus_a.load_err), 32'd0);
        check("rst_b_hours", 32'(bus_b.hours), 32'h12);

        // 415 minutes after midnight is 06:55 AM, five minutes before window 0.
        tick_a(415);
        check_time_a("t0655", 8'h06, 8'h55, 1'b0);
        cyc(1);
        check_cls_a("t0655", 1'b0, 1'b1, 3'd0);

        tick_a(5);
        check_time_a("t0700", 8'h07, 8'h00, 1'b0);
        check("t0700_latency_peak", 32'(bus_a.peak), 32'd0);
        cyc(1);
        check_cls_a("t0700", 1'b1, 1'b0, 3'd0);

        load_a(8'h11, 8'h59, 1'b0);
        cyc(1);
        check_cls_a("t1159am", 1'b0, 1'b1, 3'd0);
        tick_a(1);
        check_time_a("t1200pm", 8'h12, 8'h00, 1'b1);
        cyc(1);
        check_cls_a("t1200pm", 1'b1, 1'b0, 3'd1);

        load_a(8'h11, 8'h59, 1'b1);
        tick_a(1);
        check_time_a("t1200am", 8'h12, 8'h00, 1'b0);
        cyc(1);
        check("t1200am_peak", 32'(bus_a.peak), 32'd0);

        load_a(8'h09, 8'h59, 1'b0);
        cyc(1);
        check_cls_a("t0959", 1'b1, 1'b0, 3'd0);
        tick_a(1);
        check_time_a("t1000", 8'h10, 8'h00, 1'b0);
        cyc(1);
        check("t1000_peak", 32'(bus_a.peak), 32'd0);

        load_a(8'h07, 8'h00, 1'b1);
        cyc(1);
        check_cls_a("t1900", 1'b1, 1'b0, 3'd2);

        // Entry 0 becomes a window that wraps across midnight.
        write_a(3'd0, 8'h22, 8'h02, 1'b1);
        load_a(8'h01, 8'h30, 1'b0);
        cyc(1);
        check_cls_a("wrap0130", 1'b1, 1'b0, 3'd0);
        load_a(8'h12, 8'h30, 1'b0);
        cyc(1);
        check_cls_a("wrap0030", 1'b1, 1'b0, 3'd0);
        load_a(8'h03, 8'h00, 1'b0);
        cyc(1);
        check("wrap0300_peak", 32'(bus_a.peak), 32'd0);
        load_a(8'h09, 8'h57, 1'b1);
        cyc(1);
        check_cls_a("wrap2157", 1'b0, 1'b1, 3'd0);

        load_a(8'h13, 8'h00, 1'b0);
        check("bad_hour_err", 32'(bus_a.load_err), 32'd1);
        check_time_a("bad_hour", 8'h09, 8'h57, 1'b1);
        cyc(1);
        check("bad_hour_err_pulse", 32'(bus_a.load_err), 32'd0);
        load_a(8'h10, 8'h60, 1'b0);
        check("bad_min_err", 32'(bus_a.load_err), 32'd1);
        check_time_a("bad_min", 8'h09, 8'h57, 1'b1);

        // None of these writes may land; each would otherwise cover 21:57.
        write_a(3'd3, 8'h21, 8'h21, 1'b1);
        write_a(3'd1, 8'h1A, 8'h23, 1'b1);
        write_a(3'd1, 8'h24, 8'h23, 1'b1);
        cyc(1);
        check("bad_write_peak", 32'(bus_a.peak), 32'd0);

        bus_a.wr_en    = 1'b1;
        bus_a.wr_idx   = 3'd1;
        bus_a.wr_start = 8'h21;
        bus_a.wr_end   = 8'h21;
        bus_a.wr_ena   = 1'b1;
        bus_a.tick     = 1'b1;
        cyc(1);
        bus_a.wr_en    = 1'b0;
        bus_a.tick     = 1'b0;
        check_time_a("wr_tick", 8'h09, 8'h58, 1'b1);
        cyc(1);
        check_cls_a("wr_tick", 1'b1, 1'b0, 3'd1);

        bus_a.tick = 1'b1;
        load_a(8'h10, 8'h00, 1'b0);
        bus_a.tick = 1'b0;
        check_time_a("load_tick", 8'h10, 8'h00, 1'b0);

        load_a(8'h07, 8'h30, 1'b1);
        cyc(1);
        check_cls_a("pre_reset", 1'b1, 1'b0, 3'd2);
        #2;
        reset = 1'b1;
        #1;
        check_time_a("async_rst", 8'h12, 8'h00, 1'b0);
        check_cls_a("async_rst", 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1);

        load_a(8'h01, 8'h00, 1'b0);
        cyc(1);
        check("tbl_rst_entry0", 32'(bus_a.peak), 32'd0);
        load_a(8'h01, 8'h00, 1'b1);
        cyc(1);
        check_cls_a("tbl_rst_entry1", 1'b1, 1'b0, 3'd1);
        write_a(3'd2, 8'h12, 8'h13, 1'b1);
        cyc(1);
        check_cls_a("lowest_idx", 1'b1, 1'b0, 3'd1);

        // Three ticks per minute: a load clears the prescaler and eats a coincident tick.
        load_b(8'h10, 8'h00, 1'b0, 1'b0);
        tick_b(2);
        check("b_two_ticks", 32'(bus_b.minutes), 32'h00);
        load_b(8'h10, 8'h00, 1'b0, 1'b1);
        check("b_load_tick_hours", 32'(bus_b.hours), 32'h10);
        check("b_load_tick_min", 32'(bus_b.minutes), 32'h00);
        tick_b(2);
        check("b_presc_cleared", 32'(bus_b.minutes), 32'h00);
        tick_b(1);
        check("b_minute_adv", 32'(bus_b.minutes), 32'h01);
        load_b(8'h06, 8'h59, 1'b0, 1'b0);
        cyc(1);
        check("b_warn_disabled", 32'(bus_b.peak_warn), 32'd0);
        tick_b(3);
        cyc(1);
        check("b_peak_0700", 32'(bus_b.peak), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/peak_window_timer.md
# peak_window_timer

Parametrised time-of-day keeper and peak-hour classifier for the traffic light controller. It counts a 12-hour BCD clock (hours, minutes, AM/PM) from a 1 Hz tick enable. It holds a run-time programmable table of NUM_WIN peak windows and drives registered `peak`, `peak_warn` and `win_id` outputs that the phase-timing FSM uses to pick green durations. It replaces fixed-window combinational peak decoding: windows are programmable, may wrap across midnight, and an advance warning is produced before each window opens.

## Interface
- NUM_WIN, 3, number of peak windows (1..8)
- TICKS_PER_MIN, 60, `tick` pulses per minute
- WARN_MIN, 5, minutes of advance warning before a window start (0 disables warning)
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick  in  1  one-cycle time-base enable (1 Hz nominal)
- load_en  in  1  load time from load_* this cycle
- load_hours  in  8  BCD hour, 01..12
- load_min  in  8  BCD minute, 00..59
- load_pm  in  1  1 = PM
- wr_en  in  1  write window table entry
- wr_idx  in  3  entry index, < NUM_WIN
- wr_start  in  8  BCD start hour, 24 h, 00..23
- wr_end  in  8  BCD end hour, 24 h, 00..23, inclusive
- wr_ena  in  1  entry enable
- hours  out  8  BCD hour, 01..12
- minutes  out  8  BCD minute
- pm  out  1  PM flag
- peak  out  1  current time is inside an enabled window
- peak_warn  out  1  an enabled window opens within WARN_MIN minutes and `peak` = 0
- win_id  out  3  index of the matching window (lowest index wins); 0 when `peak` = 0
- load_err  out  1  one-cycle pulse: load rejected

## Operation
- Reset values:
  - Time is 12:00 AM: hours = 8'h12, minutes = 8'h00, pm = 0.
  - peak, peak_warn, win_id and load_err are 0.
  - Tick prescaler is 0.
  - Table: entry 0 = 07–09, entry 1 = 12–14, entry 2 = 17–19, all enabled. Entries ≥3 are disabled with 00–00.
- Prescaler: counts `tick` events from 0 to TICKS_PER_MIN-1. On the terminal count it wraps to 0 and advances the minute.
- Minute advance:
  - Minutes 59 → 00 carries into hours.
  - 11 → 12 toggles pm.
  - 12 → 01 leaves pm unchanged.
  - 11:59 PM → 12:00 AM.
- Load:
  - Accepted only when load_hours is valid BCD 01..12 and load_min is valid BCD 00..59.
  - Acceptance overwrites the time and clears the prescaler.
  - Otherwise the time is unchanged and load_err pulses for one cycle.
  - load_en has priority over a coincident tick; that tick is dropped.
- 24 h conversion (internal):
  - 12 AM → 0.
  - 1–11 AM → unchanged.
  - 12 PM → 12.
  - 1–11 PM → +12.
  - Minute-of-day mod = h24·60 + min, range 0..1439, 11 bits.
- Window match:
  - If start ≤ end: match when start ≤ h24 ≤ end.
  - If start > end (wraps midnight): match when h24 ≥ start or h24 ≤ end.
  - Disabled entries never match.
- Warning:
  - For each enabled entry, d = (start·60 − mod) mod 1440.
  - peak_warn = 1 when any entry has 1 ≤ d ≤ WARN_MIN and peak = 0.
- Table write:
  - wr_en with wr_idx ≥ NUM_WIN is ignored.
  - Entries with non-BCD or >23 hours are ignored.
  - Writes do not touch the time.

## Timing
- Time registers update on the clk edge where the tick terminal count (or accepted load) is sampled.
- peak, peak_warn and win_id are registered. They reflect time and table state one cycle after any change, so latency from the updating edge is 1 cycle.
- A table write and a minute advance in the same cycle both take effect. Outputs on the following cycle use the new table and new time.
- load_err asserts on the cycle after the rejected load_en and is high for exactly 1 cycle.
- Reset asserted mid-count clears everything asynchronously, including the programmed table, back to its reset defaults.
- Max rate: tick may be asserted every cycle. No handshake back-pressure; every input is sampled once per edge.

## Test plan
- **Reset defaults:** Reset, then TICKS_PER_MIN=1, advance 420 ticks → 07:00 AM; peak = 1 and win_id = 0 one cycle after the 07:00 update. At 06:55 → peak_warn = 1, peak = 0.
- **AM/PM rollover:** Load 11:59 AM, one minute of ticks → 12:00 PM, pm = 1, peak = 1, win_id = 1. Load 11:59 PM, one minute → 12:00 AM, pm = 0, peak = 0.
- **Window end boundary:** Load 09:59 AM, advance one minute → 10:00 AM, peak 1 → 0. Load 07:00 PM (h24 = 19) → peak = 1, win_id = 2.
- **Midnight-wrapping window:** Write entry 0 = 22–02. Check 01:30 AM → peak = 1. 03:00 AM → peak = 0. 09:57 PM with WARN_MIN = 5 → peak_warn = 1.
- **Invalid inputs:** Load hours 8'h13 or minutes 8'h60 → load_err one-cycle pulse, time unchanged. Write wr_idx = NUM_WIN → table unchanged.
- **Collisions:** Apply load_en and terminal tick in the same cycle → loaded value exactly, prescaler 0. Assert reset while peak = 1 → all outputs return to reset values immediately, without waiting for a clk edge.
